mem_wb_stage: RTL
=================

# mem_wb_stage

Memory-access and write-back stage of the 16-bit pipelined CPU, sitting directly downstream of the EX stage. It consumes the ALU result, store data, destination register and memory/write-back control bits produced in EX. It performs loads and stores against a private multi-cycle data memory and presents the write-back triple (register, data, enable) to the register file. It stalls upstream while a memory access is in flight.

## Interface
- DEPTH, 1024: data memory size in 16-bit words.
- ADDR_W, 10: word-index width, log2(DEPTH).
- LATENCY, 2: clock cycles per memory access; legal range 1..15.
- clk  in  1  pipeline clock; all state updates on falling edge, matching the rest of the pipeline.
- rst_n  in  1  synchronous, active-low reset, sampled on the falling edge of clk.
- ex_valid  in  1  EX presents an instruction this cycle.
- ex_alu_out  in  16  ALU result / byte address.
- ex_store_data  in  16  RD2 value for stores.
- ex_wr  in  2  destination register.
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  in  1 each  control bits from EX.
- mem_stall  out  1  high: upstream must hold its current instruction.
- wb_valid  out  1  write-back triple is meaningful.
- wb_wr  out  2  register-file write register.
- wb_wd  out  16  register-file write data.
- wb_regwrite  out  1  register-file write enable; always equals the latched regwrite AND wb_valid.
- misaligned  out  1  sticky error flag.

## Operation
- FSM with two states:
  - IDLE (accepting). Reset state.
  - BUSY (access in flight, down-counter cnt).
- Accept condition: IDLE and ex_valid. In BUSY, ex_* inputs are ignored; upstream re-presents the instruction once the stall clears.
- Accepted non-memory op (memread=memwrite=0): wb_wr=ex_wr, wb_wd=ex_alu_out, wb_regwrite=ex_regwrite, wb_valid=1. State stays IDLE.
- Accepted memory op:
  - Latch address, store data, wr and control bits.
  - Load cnt=LATENCY and go to BUSY.
  - Drive wb_valid=0 and wb_regwrite=0 (bubble).
- Each BUSY edge with cnt>1: decrement cnt, keep the bubble.
- BUSY edge with cnt==1: the access completes and the state returns to IDLE.
  - Load: wb_wd = mem[index]; wb_wd = latched alu_out if memtoreg=0; wb_regwrite = latched regwrite.
  - Store: mem[index] = latched store data; wb_valid=1 with wb_regwrite=0.
- mem_stall = (state==BUSY). It is decoded from state only, with no combinational path from ex_* inputs.
- Idle cycle with ex_valid=0: wb_valid=0, wb_regwrite=0; wb_wr and wb_wd hold their previous values.
- Address index = ex_alu_out[ADDR_W:1]. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- ex_alu_out[0]=1 on a memory op: set misaligned; the access still proceeds with bit 0 ignored.
- memread and memwrite both high: treated as a store; also sets misaligned.
- misaligned clears only on reset.
- Memory contents are not reset; they are undefined after power-up.

## Timing
- Reset values: state IDLE, cnt 0, mem_stall 0, wb_valid 0, wb_wr 0, wb_wd 0, wb_regwrite 0, misaligned 0.
- Non-memory op accepted at edge N: write-back visible after edge N (1-cycle latency, full throughput).
- Memory op accepted at edge N:
  - mem_stall is high from after edge N through edge N+LATENCY.
  - Write-back is visible after edge N+LATENCY.
  - The next instruction is accepted at edge N+LATENCY+1.
- Store commits to memory exactly at edge N+LATENCY, never earlier.
- rst_n low on any edge while BUSY aborts the access: no memory write, all outputs return to reset values on that edge.
- Reset has priority over acceptance and completion on the same edge.

## Structure
- Shared constants file (cpu_defs):
  - control-vector bit positions (RegWrite, MemRead, MemWrite, MemtoReg);
  - FSM state encoding;
  - default DEPTH and LATENCY.
- One sub-module, data_mem:
  - DEPTH×16 array;
  - synchronous write on the falling edge when we=1;
  - combinational read of the addressed word.
- The FSM, counter and MEM/WB output register stay in mem_wb_stage.

## Test plan
- Reset: rst_n=0 for 2 edges with ex_valid=1 -> all outputs 0, mem_stall=0, no memory write.
- ALU passthrough: ex_valid=1, regwrite=1, wr=2, alu_out=0x0016, no mem op -> after next edge wb_valid=1, wb_wr=2, wb_wd=0x0016, wb_regwrite=1, mem_stall=0.
- Store/load at LATENCY=2:
  - store 0x1234 to 0x0004 at edge N -> mem_stall high 2 cycles; wb_valid=1, wb_regwrite=0 after N+2;
  - then load 0x0004, wr=3 -> wb_wd=0x1234, wb_regwrite=1 two edges after acceptance.
- Stall holds upstream: present add result 0x0005 (wr=1) while BUSY -> ignored until IDLE; exactly one write-back of 0x0005 after acceptance; no duplicate.
- Wrap and misalignment:
  - store 0xBEEF to 0x0805 -> misaligned=1;
  - load 0x0004 returns 0xBEEF (index wraps to 2);
  - misaligned stays 1 until reset.
- Reset mid-access: preload 0x1111 at 0x0008; store 0x2222 to 0x0008; assert rst_n=0 on the first BUSY edge; a later load from 0x0008 returns 0x1111.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// ============================================================================
// Module      : mem_wb_stage_pkg
// Description : Shared CPU constants for the MEM/WB stage: control-vector bit
//               positions, FSM state encoding and default memory geometry.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_wb_stage_pkg;

  localparam int c_DEPTH   = 1024;
  localparam int c_LATENCY = 2;

  // Control vector layout as produced by EX: {MemtoReg, MemWrite, MemRead, RegWrite}
  localparam int c_CTRL_W        = 4;
  localparam int c_CTRL_REGWRITE = 0;
  localparam int c_CTRL_MEMREAD  = 1;
  localparam int c_CTRL_MEMWRITE = 2;
  localparam int c_CTRL_MEMTOREG = 3;

  typedef logic [c_CTRL_W-1:0] ctrl_t;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_BUSY = 1'b1;

  function automatic ctrl_t pack_ctrl(input logic regwrite, input logic memread,
                                      input logic memwrite, input logic memtoreg);
    ctrl_t v;
    v = '0;
    v[c_CTRL_REGWRITE] = regwrite;
    v[c_CTRL_MEMREAD]  = memread;
    v[c_CTRL_MEMWRITE] = memwrite;
    v[c_CTRL_MEMTOREG] = memtoreg;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_data_mem.sv
// ============================================================================
// Module      : data_mem
// Description : DEPTH x 16 data memory, falling-edge synchronous write,
//               combinational read. Contents are not reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module data_mem #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_wdata,
  output logic [15:0]       o_rdata
);

  logic [15:0] r_mem [DEPTH];

  always_ff @(negedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline stage with multi-cycle private data memory,
//               upstream stall and registered write-back triple.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH   = c_DEPTH,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = c_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_store_data,
  input  logic [1:0]  ex_wr,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_memtoreg,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [1:0]  wb_wr,
  output logic [15:0] wb_wd,
  output logic        wb_regwrite,
  output logic        misaligned
);

  localparam logic [3:0] c_LAT = 4'(LATENCY);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [15:0]       r_alu;
  logic [15:0]       r_sdata;
  logic [1:0]        r_wr;
  logic              r_regwrite;
  logic              r_is_store;
  logic              r_memtoreg;

  logic              r_wb_valid;
  logic [1:0]        r_wb_wr;
  logic [15:0]       r_wb_wd;
  logic              r_wb_regwrite;
  logic              r_misaligned;

  ctrl_t             w_ctrl;
  logic              w_accept;
  logic              w_is_mem;
  logic              w_done;
  logic              w_mem_we;
  logic              w_stall;
  logic [15:0]       w_rdata;

  assign w_ctrl   = pack_ctrl(ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg);
  assign w_accept = (r_state == c_ST_IDLE) && ex_valid;
  assign w_is_mem = w_ctrl[c_CTRL_MEMREAD] | w_ctrl[c_CTRL_MEMWRITE];
  assign w_done   = (r_state == c_ST_BUSY) && (r_cnt == 4'd1);

  // State register
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_accept && w_is_mem) w_state_nxt = c_ST_BUSY;
      c_ST_BUSY: if (r_cnt == 4'd1)        w_state_nxt = c_ST_IDLE;
      default:                             w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State-decoded outputs; the write is gated by rst_n so a reset edge aborts it
  always_comb begin
    w_stall  = 1'b0;
    w_mem_we = 1'b0;
    case (r_state)
      c_ST_BUSY: begin
        w_stall  = 1'b1;
        w_mem_we = w_done && r_is_store && rst_n;
      end
      default: ;
    endcase
  end

  // Access latch, latency counter and MEM/WB output register
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      r_cnt         <= 4'd0;
      r_idx         <= '0;
      r_alu         <= 16'h0000;
      r_sdata       <= 16'h0000;
      r_wr          <= 2'd0;
      r_regwrite    <= 1'b0;
      r_is_store    <= 1'b0;
      r_memtoreg    <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_wr       <= 2'd0;
      r_wb_wd       <= 16'h0000;
      r_wb_regwrite <= 1'b0;
      r_misaligned  <= 1'b0;
    end else if (w_accept) begin
      if (w_is_mem) begin
        r_cnt         <= c_LAT;
        r_idx         <= ex_alu_out[ADDR_W:1];
        r_alu         <= ex_alu_out;
        r_sdata       <= ex_store_data;
        r_wr          <= ex_wr;
        r_regwrite    <= w_ctrl[c_CTRL_REGWRITE];
        // read+write together is executed as a store
        r_is_store    <= w_ctrl[c_CTRL_MEMWRITE];
        r_memtoreg    <= w_ctrl[c_CTRL_MEMTOREG];
        r_wb_valid    <= 1'b0;
        r_wb_regwrite <= 1'b0;
        if (ex_alu_out[0] || (w_ctrl[c_CTRL_MEMREAD] && w_ctrl[c_CTRL_MEMWRITE])) begin
          r_misaligned <= 1'b1;
        end
      end else begin
        r_wb_valid    <= 1'b1;
        r_wb_wr       <= ex_wr;
        r_wb_wd       <= ex_alu_out;
        r_wb_regwrite <= w_ctrl[c_CTRL_REGWRITE];
      end
    end else if (r_state == c_ST_BUSY) begin
      if (r_cnt > 4'd1) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_cnt      <= 4'd0;
        r_wb_valid <= 1'b1;
        r_wb_wr    <= r_wr;
        if (r_is_store) begin
          r_wb_wd       <= r_alu;
          r_wb_regwrite <= 1'b0;
        end else begin
          r_wb_wd       <= r_memtoreg ? w_rdata : r_alu;
          r_wb_regwrite <= r_regwrite;
        end
      end
    end else begin
      r_wb_valid    <= 1'b0;
      r_wb_regwrite <= 1'b0;
    end
  end

  data_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (r_idx),
    .i_wdata (r_sdata),
    .o_rdata (w_rdata)
  );

  assign mem_stall   = w_stall;
  assign wb_valid    = r_wb_valid;
  assign wb_wr       = r_wb_wr;
  assign wb_wd       = r_wb_wd;
  assign wb_regwrite = r_wb_regwrite;
  assign misaligned  = r_misaligned;

endmodule

`default_nettype wire
